// File: rtl/small_number_first_sorter_pkg.sv
// Shared types and default sizing for the ascending burst sorter.
package sorter_pkg;

    localparam int SORTER_WIDTH = 8;
    localparam int SORTER_DEPTH = 4;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

endpackage

// File: rtl/small_number_first_sorter_if.sv
// Input and output valid/ready streams of the sorter.
interface small_number_first_sorter_if
    import sorter_pkg::*;
#(
    parameter int WIDTH = SORTER_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/small_number_first_sorter_compare_swap.sv
// Unsigned compare-and-swap; ties keep aIn on the low side.
module compare_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic w_swap;

    assign w_swap = aIn > bIn;
    assign lo     = w_swap ? bIn : aIn;
    assign hi     = w_swap ? aIn : bIn;

endmodule

// File: rtl/small_number_first_sorter.sv
// Loads a burst, sorts it with odd-even transposition, drains smallest first.
module small_number_first_sorter
    import sorter_pkg::*;
#(
    parameter int WIDTH = SORTER_WIDTH,
    parameter int DEPTH = SORTER_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    small_number_first_sorter_if.slave   bus,
    output logic                         busy
);

    localparam int             CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [CW-1:0]    r_wr_cnt;
    logic [CW-1:0]    r_pass_cnt;
    logic [CW-1:0]    r_rd_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_busy;

    logic [WIDTH-1:0] w_lo   [DEPTH-1];
    logic [WIDTH-1:0] w_hi   [DEPTH-1];
    logic [WIDTH-1:0] w_pass [DEPTH];
    logic [CW-1:0]    w_rd_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    genvar g;
    generate
        for (g = 0; g < DEPTH - 1; g++) begin : g_cs
            compare_swap #(
                .WIDTH (WIDTH)
            ) u_cs (
                .aIn (r_regs[g]),
                .bIn (r_regs[g+1]),
                .lo  (w_lo[g]),
                .hi  (w_hi[g])
            );
        end
    endgenerate

    // Only pairs whose lower index matches the pass parity take part.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            w_pass[j] = r_regs[j];
        end
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (j[0] == r_pass_cnt[0]) begin
                w_pass[j]   = w_lo[j];
                w_pass[j+1] = w_hi[j];
            end
        end
    end

    assign w_in_fire  = bus.in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_rd_nxt   = r_rd_idx + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LOAD;
            r_wr_cnt    <= '0;
            r_pass_cnt  <= '0;
            r_rd_idx    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            unique case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_regs[r_wr_cnt] <= bus.in_data;
                        if (r_wr_cnt == LAST) begin
                            r_wr_cnt   <= '0;
                            r_state    <= SORT;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + CW'(1);
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_regs[i] <= w_pass[i];
                    end
                    if (r_pass_cnt == LAST) begin
                        r_pass_cnt <= '0;
                        r_state    <= DRAIN;
                    end else begin
                        r_pass_cnt <= r_pass_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle primes the registered output mux.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_regs[r_rd_idx];
                        r_out_last  <= (r_rd_idx == LAST);
                    end else if (w_out_fire) begin
                        if (r_out_last) begin
                            r_state     <= LOAD;
                            r_rd_idx    <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_rd_idx   <= w_rd_nxt;
                            r_out_data <= r_regs[w_rd_nxt];
                            r_out_last <= (w_rd_nxt == LAST);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;

endmodule

// File: tb/tb_small_number_first_sorter.sv
// Randomised scoreboard bench for small_number_first_sorter.
module tb_small_number_first_sorter;
    import sorter_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    small_number_first_sorter_if #(.WIDTH(W)) bus ();

    small_number_first_sorter #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   out_hs   = 0;
    int   rmode    = 0;
    bit   exp_busy = 0;
    bit   wait_1st = 0;
    int   in_cnt   = 0;
    int   acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, req);
        end
    endtask

    // Reference: repeatedly take the smallest remaining word.
    task automatic push_burst(input logic [W-1:0] v[$]);
        logic [W-1:0] pool[$];
        exp_t e;
        int mi;
        pool = v;
        for (int k = 0; k < D; k++) begin
            mi = 0;
            for (int i = 1; i < pool.size(); i++)
                if (pool[i] < pool[mi]) mi = i;
            e.d    = pool[mi];
            e.last = (k == D - 1);
            exp_q.push_back(e);
            pool.delete(mi);
        end
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL in_accept_timeout got %0d want <300", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] v[$];
        v.push_back(a);
        v.push_back(b);
        v.push_back(c);
        v.push_back(d);
        foreach (v[i]) send_word(v[i]);
        push_burst(v);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !exp_busy) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout got %0d want idle", exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_busy = 0;
            wait_1st = 0;
            in_cnt   = 0;
        end else begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("in_ready", 32'(bus.in_ready), 32'(!exp_busy));
            if (!exp_busy || wait_1st) begin
                if (bus.out_valid && wait_1st) begin
                    chk("latency", cyc - acc_cyc, 6);
                    wait_1st = 0;
                end else begin
                    chk("out_valid_low", 32'(bus.out_valid), 0);
                end
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_extra got %0h want none", bus.out_data);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q[0].d));
                    chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
                    if (bus.out_ready) begin
                        if (exp_q[0].last) exp_busy = 0;
                        void'(exp_q.pop_front());
                        out_hs++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                in_cnt++;
                if (in_cnt == D) begin
                    in_cnt   = 0;
                    exp_busy = 1;
                    wait_1st = 1;
                    acc_cyc  = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

        send4(8'h1C, 8'hFA, 8'hFC, 8'h1C);
        send4(8'hFF, 8'h80, 8'h01, 8'h00);
        send4(8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle();

        send4(8'h44, 8'h11, 8'h33, 8'h22);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_ready) && n < 100);
        @(posedge clk);
        #1;
        rmode = 2;
        repeat (3) @(posedge clk);
        #1;
        rmode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_last && bus.out_ready) && n < 100);
        bus.in_valid = 1'b0;
        wait_idle();

        send4(8'h10, 8'h30, 8'h20, 8'h40);
        base = out_hs;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_hs < base + 2 && n < 100);
        chk("pre_reset_hs", out_hs - base, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        chk("abort_out_data", 32'(bus.out_data), 0);
        @(posedge clk);
        #1;
        send4(8'h03, 8'h02, 8'h01, 8'h04);
        wait_idle();

        rmode = 1;
        for (int b = 0; b < 24; b++) begin
            if (b[0])
                send4(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                      8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            else
                send4(8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom));
        end
        wait_idle();
        rmode = 0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
